// File: rtl/axi_frame_sched.sv
// Double-buffered frame scheduler: issues 16-beat AXI write/read bursts into two frame banks that swap on vsync.
// Define DF_SCHED_STAT_EN to count playback frames that were swapped out before being fully read.
module axi_frame_sched #(
    parameter int unsigned H_WIDTH   = 1920,
    parameter int unsigned V_HEIGHT  = 1080,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        vs_i,
    input  logic        wr_req_i,
    input  logic        rd_req_i,
    output logic        wr_grant_o,
    output logic        rd_grant_o,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_awaddr,
    output logic [3:0]  m_axi_awlen,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [31:0] m_axi_araddr,
    output logic [3:0]  m_axi_arlen,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    input  logic        m_axi_rvalid,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rready,
    output logic [15:0] frame_drop_o,
    output logic [1:0]  state_o
);

    localparam int unsigned FRAME_BURSTS = H_WIDTH * V_HEIGHT / 16;
    localparam logic [31:0] FRAME_BYTES  = 32'(H_WIDTH * V_HEIGHT * 4);
    localparam int unsigned CNT_W        = $clog2(FRAME_BURSTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_BURSTS);
    localparam logic [3:0] OUT_MAX       = 4'(MAX_OUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_AR   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [3:0]       wr_out_q, wr_out_d;
    logic [3:0]       rd_out_q, rd_out_d;
    logic             vs_q, vs_d;
    logic             swap_pend_q, swap_pend_d;
    logic             last_wr_q, last_wr_d;

    logic aw_hs, ar_hs, b_done, r_done, wr_elig, rd_elig, swap_apply;
    logic [31:0] wr_base, rd_base;

    // valid/ready: valid rises only in AW/AR and holds with a stable address until ready;
    // a transfer happens in any cycle where both are high, including the cycle valid rises.
    assign aw_hs      = (state_q == ST_AW) && m_axi_awready;
    assign ar_hs      = (state_q == ST_AR) && m_axi_arready;
    assign b_done     = m_axi_bvalid && (wr_out_q != 4'd0);
    assign r_done     = m_axi_rvalid && m_axi_rready && m_axi_rlast && (rd_out_q != 4'd0);
    assign wr_elig    = wr_req_i && (wr_cnt_q < CNT_MAX) && (wr_out_q < OUT_MAX);
    assign rd_elig    = rd_req_i && (rd_cnt_q < CNT_MAX) && (rd_out_q < OUT_MAX);
    assign swap_apply = (state_q == ST_IDLE) && swap_pend_q;

    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        last_wr_d   = last_wr_q;
        vs_d        = vs_i;
        swap_pend_d = swap_pend_q | (vs_i & ~vs_q);
        case (state_q)
            ST_IDLE: begin
                if (swap_pend_q) begin
                    wr_bank_d   = ~wr_bank_q;
                    wr_cnt_d    = '0;
                    rd_cnt_d    = '0;
                    swap_pend_d = 1'b0;
                end else if (wr_elig && (!rd_elig || !last_wr_q)) begin
                    state_d   = ST_AW;
                    last_wr_d = 1'b1;
                end else if (rd_elig) begin
                    state_d   = ST_AR;
                    last_wr_d = 1'b0;
                end
            end
            ST_AW: begin
                if (aw_hs) begin
                    state_d = ST_IDLE;
                    if (wr_cnt_q < CNT_MAX) wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
            end
            ST_AR: begin
                if (ar_hs) begin
                    state_d = ST_IDLE;
                    if (rd_cnt_q < CNT_MAX) rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Issue and completion in the same cycle cancel out.
    always_comb begin
        wr_out_d = wr_out_q;
        rd_out_d = rd_out_q;
        if (aw_hs && !b_done) wr_out_d = wr_out_q + 4'd1;
        else if (!aw_hs && b_done) wr_out_d = wr_out_q - 4'd1;
        if (ar_hs && !r_done) rd_out_d = rd_out_q + 4'd1;
        else if (!ar_hs && r_done) rd_out_d = rd_out_q - 4'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            wr_bank_q   <= 1'b1;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_out_q    <= 4'd0;
            rd_out_q    <= 4'd0;
            vs_q        <= 1'b0;
            swap_pend_q <= 1'b0;
            last_wr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_out_q    <= wr_out_d;
            rd_out_q    <= rd_out_d;
            vs_q        <= vs_d;
            swap_pend_q <= swap_pend_d;
            last_wr_q   <= last_wr_d;
        end
    end

`ifdef DF_SCHED_STAT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (swap_apply && (rd_cnt_q < CNT_MAX) && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) drop_q <= 16'd0;
        else         drop_q <= drop_d;
    end

    assign frame_drop_o = drop_q;
`else
    assign frame_drop_o = 16'd0;
`endif

    // Bank 1 holds the write frame out of reset; the read bank is always the other one.
    assign wr_base = wr_bank_q ? (BASE_ADDR + FRAME_BYTES) : BASE_ADDR;
    assign rd_base = wr_bank_q ? BASE_ADDR : (BASE_ADDR + FRAME_BYTES);

    assign m_axi_awvalid = (state_q == ST_AW);
    assign m_axi_arvalid = (state_q == ST_AR);
    assign m_axi_awaddr  = wr_base + (32'(wr_cnt_q) << 6);
    assign m_axi_araddr  = rd_base + (32'(rd_cnt_q) << 6);
    assign m_axi_awlen   = 4'hF;
    assign m_axi_arlen   = 4'hF;
    assign m_axi_bready  = 1'b1;
    assign wr_grant_o    = aw_hs;
    assign rd_grant_o    = ar_hs;
    assign state_o       = state_q;

    // swap_apply only feeds the drop counter; keep it referenced in the default build.
    logic unused_ok;
    assign unused_ok = swap_apply;

endmodule

// File: tb/tb_axi_frame_sched.sv
// Self-checking bench for axi_frame_sched: directed scenarios plus randomized frames checked
// against a burst-address scoreboard and outstanding-count model.
`timescale 1ns/1ps
module tb_axi_frame_sched;

    localparam int unsigned H_WIDTH  = 64;
    localparam int unsigned V_HEIGHT = 2;
    localparam int unsigned MAX_OUT  = 4;
    localparam logic [31:0] BASE     = 32'h1000_0000;
    localparam int          BURSTS   = H_WIDTH * V_HEIGHT / 16;
    localparam logic [31:0] FBYTES   = 32'(H_WIDTH * V_HEIGHT * 4);

    logic        clk = 1'b0, rst_n = 1'b0, vs = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
    logic        awready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0, rlast = 1'b0, rready = 1'b0;
    logic        wr_grant, rd_grant, awvalid, arvalid, bready;
    logic [31:0] awaddr, araddr;
    logic [3:0]  awlen, arlen;
    logic [15:0] frame_drop;
    logic [1:0]  dbg_state;

    axi_frame_sched #(
        .H_WIDTH(H_WIDTH), .V_HEIGHT(V_HEIGHT), .BASE_ADDR(BASE), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .vs_i(vs), .wr_req_i(wr_req), .rd_req_i(rd_req),
        .wr_grant_o(wr_grant), .rd_grant_o(rd_grant),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_rvalid(rvalid), .m_axi_rlast(rlast),
        .m_axi_rready(rready), .frame_drop_o(frame_drop), .state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_ar_q[$];
    int          b_due_q[$];
    int          r_due_q[$];
    int          grant_log[$];
    int          wbank, b_out, r_out, cyc, last_g, wr_gcnt, rd_gcnt, b_lat;
    bit          b_hold, b_one;
    logic [15:0] exp_drop;
    logic        aw_stall, ar_stall, aw_hs_m, ar_hs_m;
    logic [31:0] aw_stall_addr, ar_stall_addr;

    function automatic logic [31:0] bank_base(input int b);
        return (b != 0) ? BASE + FBYTES : BASE;
    endfunction

    task automatic model_reload();
        exp_aw_q.delete();
        exp_ar_q.delete();
        for (int i = 0; i < BURSTS; i++) begin
            exp_aw_q.push_back(bank_base(wbank) + 32'(i * 64));
            exp_ar_q.push_back(bank_base(1 - wbank) + 32'(i * 64));
        end
    endtask

    task automatic model_swap();
`ifdef DF_SCHED_STAT_EN
        if (exp_ar_q.size() > 0 && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
`endif
        wbank = 1 - wbank;
        model_reload();
    endtask

    task automatic model_reset();
        wbank = 1;
        model_reload();
        b_out = 0; r_out = 0; exp_drop = 16'd0; last_g = -100;
        b_due_q.delete(); r_due_q.delete(); grant_log.delete();
        wr_gcnt = 0; rd_gcnt = 0; b_hold = 0; b_one = 0; b_lat = 0;
    endtask

    // Monitor: outputs settle well before the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            aw_stall = 1'b0;
            ar_stall = 1'b0;
        end else begin
            aw_hs_m = awvalid && awready;
            ar_hs_m = arvalid && arready;
            if (aw_stall) begin
                check("aw_hold_valid", awvalid, 1);
                check("aw_hold_addr", awaddr, aw_stall_addr);
            end
            if (ar_stall) begin
                check("ar_hold_valid", arvalid, 1);
                check("ar_hold_addr", araddr, ar_stall_addr);
            end
            check("wr_grant", wr_grant, aw_hs_m);
            check("rd_grant", rd_grant, ar_hs_m);
            if (aw_hs_m || ar_hs_m) begin
                check("grant_spacing", (cyc - last_g) >= 2, 1);
                last_g = cyc;
            end
            if (aw_hs_m) begin
                wr_gcnt++;
                grant_log.push_back(0);
                check("aw_frame_room", exp_aw_q.size() > 0, 1);
                if (exp_aw_q.size() > 0) check("awaddr", awaddr, exp_aw_q.pop_front());
                b_due_q.push_back(cyc + ((b_lat > 0) ? b_lat : int'($urandom_range(1, 8))));
            end
            if (ar_hs_m) begin
                rd_gcnt++;
                grant_log.push_back(1);
                check("ar_frame_room", exp_ar_q.size() > 0, 1);
                if (exp_ar_q.size() > 0) check("araddr", araddr, exp_ar_q.pop_front());
                r_due_q.push_back(cyc + int'($urandom_range(1, 8)));
            end
            b_out = b_out + (aw_hs_m ? 1 : 0) - (bvalid ? 1 : 0);
            r_out = r_out + (ar_hs_m ? 1 : 0) - ((rvalid && rready && rlast) ? 1 : 0);
            if (aw_hs_m) check("wr_out_limit", b_out <= int'(MAX_OUT), 1);
            if (ar_hs_m) check("rd_out_limit", r_out <= int'(MAX_OUT), 1);
            aw_stall = awvalid && !awready;
            ar_stall = arvalid && !arready;
            aw_stall_addr = awaddr;
            ar_stall_addr = araddr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        bvalid = 1'b0;
        if (b_due_q.size() > 0 && b_due_q[0] <= cyc && (!b_hold || b_one)) begin
            bvalid = 1'b1;
            void'(b_due_q.pop_front());
            b_one = 0;
        end
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
        if (r_due_q.size() > 0 && r_due_q[0] <= cyc) begin
            rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
            void'(r_due_q.pop_front());
        end else if (r_out > 0 && $urandom_range(0, 3) == 0) begin
            rvalid = 1'b1; rready = 1'b1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vs = 1'b0; wr_req = 1'b0; rd_req = 1'b0; awready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0; rready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_awvalid(input int bound);
        bit seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            cycle();
            seen = awvalid;
        end
        check("awvalid_timeout", seen, 1);
    endtask

    task automatic frame_boundary();
        wr_req = 1'b0; rd_req = 1'b0; awready = 1'b1; arready = 1'b1;
        run(4);
        vs = 1'b1;
        run(2);
        vs = 1'b0;
        run(3);
        model_swap();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc = 0;
        do_reset();
        check("rst_awvalid", awvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_wr_grant", wr_grant, 0);
        check("rst_rd_grant", rd_grant, 0);
        check("rst_awaddr", awaddr, BASE + FBYTES);
        check("rst_araddr", araddr, BASE);
        check("awlen", awlen, 4'hF);
        check("arlen", arlen, 4'hF);
        check("bready", bready, 1);
        check("rst_frame_drop", frame_drop, 0);

        // Round robin with both directions requesting, write first after reset.
        wr_req = 1'b1; rd_req = 1'b1; awready = 1'b1; arready = 1'b1; b_lat = 2;
        for (int i = 0; i < 40 && grant_log.size() < 4; i++) cycle();
        check("rr_timeout", grant_log.size() >= 4, 1);
        if (grant_log.size() >= 4)
            for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), grant_log[i], i % 2);
        run(80);
        check("rr_aw_all_issued", exp_aw_q.size(), 0);
        check("rr_ar_all_issued", exp_ar_q.size(), 0);

        // Full write frame then saturation.
        do_reset();
        wr_req = 1'b1; awready = 1'b1; b_lat = 2;
        run(40);
        check("wr_frame_grants", wr_gcnt, BURSTS);
        run(10);
        check("wr_saturated", wr_gcnt, BURSTS);
        check("wr_queue_empty", exp_aw_q.size(), 0);

        // awready held low for five AW cycles.
        do_reset();
        wr_req = 1'b1;
        wait_awvalid(10);
        run(4);
        check("aw_stall_no_grant", wr_gcnt, 0);
        awready = 1'b1;
        cycle();
        wr_req = 1'b0;
        check("aw_stall_one_grant", wr_gcnt, 1);
        run(5);

        // Outstanding limit with responses withheld.
        do_reset();
        b_hold = 1; wr_req = 1'b1; awready = 1'b1;
        run(30);
        check("max_out_grants", wr_gcnt, MAX_OUT);
        b_one = 1;
        run(10);
        check("max_out_after_b", wr_gcnt, MAX_OUT + 1);
        b_hold = 0;
        run(40);

        // vsync while an AW waits: swap lands after that handshake.
        do_reset();
        wr_req = 1'b1;
        wait_awvalid(10);
        vs = 1'b1;
        run(2);
        vs = 1'b0;
        run(2);
        awready = 1'b1;
        cycle();
        model_swap();
        rd_req = 1'b1; arready = 1'b1;
        cycle();
        check("swap_awaddr", awaddr, BASE);
        check("swap_araddr", araddr, BASE + FBYTES);
        run(80);
        check("swap_aw_all_issued", exp_aw_q.size(), 0);
        check("swap_ar_all_issued", exp_ar_q.size(), 0);

        // Playback drop accounting: 3 reads then swap, then a full read frame then swap.
        do_reset();
        rd_req = 1'b1; arready = 1'b1;
        for (int i = 0; i < 30 && rd_gcnt < 3; i++) cycle();
        rd_req = 1'b0;
        check("drop_setup_reads", rd_gcnt, 3);
        frame_boundary();
        check("drop_partial", frame_drop, exp_drop);
        rd_req = 1'b1;
        run(60);
        check("drop_full_reads", exp_ar_q.size(), 0);
        frame_boundary();
        check("drop_full", frame_drop, exp_drop);

        // Randomized frames.
        do_reset();
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 150; i++) begin
                wr_req  = ($urandom_range(0, 3) != 0);
                rd_req  = ($urandom_range(0, 3) != 0);
                awready = 1'($urandom_range(0, 1));
                arready = 1'($urandom_range(0, 1));
                cycle();
            end
            if ($urandom_range(0, 2) != 0) begin
                wr_req = 1'b1; rd_req = 1'b1; awready = 1'b1; arready = 1'b1;
                run(80);
                check("rand_aw_all_issued", exp_aw_q.size(), 0);
                check("rand_ar_all_issued", exp_ar_q.size(), 0);
            end
            frame_boundary();
            check("rand_frame_drop", frame_drop, exp_drop);
        end

        // Reset during a pending AW drops valid at once and nothing is reissued.
        do_reset();
        wr_req = 1'b1;
        wait_awvalid(10);
        #2 rst_n = 1'b0;
        #1 check("aw_drop_on_reset", awvalid, 0);
        wr_req = 1'b0; awready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(10);
        check("no_reissue", wr_gcnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog");
    end

endmodule
